regfile_alu_pipe: RTL and testbench

Parametrised successor to the single-cycle register-file/ALU datapath. It contains a 2^ADDR_WIDTH-entry register file with x0 hardwired to zero, an immediate/register operand mux, and an 8-operation ALU. A single pipeline register separates execute from write-back, and a write-back-to-execute forwarding path lets back-to-back dependent operations run without stalls. The block sits between the control unit/immediate generator and the branch/PC logic; EQ feeds the branch decision and a0 exposes x10 for test and debug.

---
 rtl/regfile_alu_pipe_if.sv | 30 +++
 rtl/regfile_alu_pipe.sv | 85 ++++++++
 tb/tb_regfile_alu_pipe.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/regfile_alu_pipe_if.sv
// Operation/result bundle between the control unit and the register-file/ALU pipe.
// The master side drives operations and the slave side (the datapath) returns results.
interface regfile_alu_pipe_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CTRL_WIDTH = 3
);
   logic                  valid_in;
   logic [ADDR_WIDTH-1:0] AD1;
   logic [ADDR_WIDTH-1:0] AD2;
   logic [ADDR_WIDTH-1:0] AD3;
   logic                  WE3;
   logic [DATA_WIDTH-1:0] ImmOp;
   logic                  ALUsrc;
   logic [CTRL_WIDTH-1:0] ALUctrl;
   logic [DATA_WIDTH-1:0] result;
   logic                  EQ;
   logic                  valid_out;
   logic [DATA_WIDTH-1:0] a0;

   modport master (
      output valid_in, AD1, AD2, AD3, WE3, ImmOp, ALUsrc, ALUctrl,
      input  result, EQ, valid_out, a0
   );

   modport slave (
      input  valid_in, AD1, AD2, AD3, WE3, ImmOp, ALUsrc, ALUctrl,
      output result, EQ, valid_out, a0
   );
endinterface

// File: rtl/regfile_alu_pipe.sv
// Register file + 8-op ALU with one execute/write-back pipeline register and
// write-back-to-execute forwarding, so dependent ops issue back to back.
module regfile_alu_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CTRL_WIDTH = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   regfile_alu_pipe_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int SHW   = $clog2(DATA_WIDTH);

   localparam logic [CTRL_WIDTH-1:0] OP_ADD = 'd0;
   localparam logic [CTRL_WIDTH-1:0] OP_SUB = 'd1;
   localparam logic [CTRL_WIDTH-1:0] OP_AND = 'd2;
   localparam logic [CTRL_WIDTH-1:0] OP_OR  = 'd3;
   localparam logic [CTRL_WIDTH-1:0] OP_XOR = 'd4;
   localparam logic [CTRL_WIDTH-1:0] OP_SLL = 'd5;
   localparam logic [CTRL_WIDTH-1:0] OP_SRL = 'd6;

   logic [DATA_WIDTH-1:0] rf_q [DEPTH];
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  eq_q, eq_d;
   logic                  vld_q;
   logic [ADDR_WIDTH-1:0] wb_rd_q;
   logic                  wb_we_q;
   logic [DATA_WIDTH-1:0] op1, op2;
   logic [SHW-1:0]        shamt;

   // Only the one-cycle-old producer is still in flight; older ones are in rf_q.
   function automatic logic [DATA_WIDTH-1:0] fwd(input logic [ADDR_WIDTH-1:0] a);
      if (a == '0)                      return '0;
      else if (wb_we_q && wb_rd_q == a) return result_q;
      else                              return rf_q[a];
   endfunction

   always_comb begin
      op1      = fwd(bus.AD1);
      op2      = bus.ALUsrc ? bus.ImmOp : fwd(bus.AD2);
      shamt    = op2[SHW-1:0];
      eq_d     = (op1 == op2);
      result_d = '0;
      case (bus.ALUctrl)
         OP_ADD:  result_d = op1 + op2;
         OP_SUB:  result_d = op1 - op2;
         OP_AND:  result_d = op1 & op2;
         OP_OR:   result_d = op1 | op2;
         OP_XOR:  result_d = op1 ^ op2;
         OP_SLL:  result_d = op1 << shamt;
         OP_SRL:  result_d = op1 >> shamt;
         default: result_d[0] = ($signed(op1) < $signed(op2));
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
         result_q <= '0;
         eq_q     <= 1'b0;
         vld_q    <= 1'b0;
         wb_rd_q  <= '0;
         wb_we_q  <= 1'b0;
      end else begin
         if (wb_we_q) rf_q[wb_rd_q] <= result_q;
         if (bus.valid_in) begin
            result_q <= result_d;
            eq_q     <= eq_d;
            wb_rd_q  <= bus.AD3;
            // x0 writes are killed here so the array entry never changes.
            wb_we_q  <= bus.WE3 && (bus.AD3 != '0);
            vld_q    <= 1'b1;
         end else begin
            wb_we_q  <= 1'b0;
            vld_q    <= 1'b0;
         end
      end
   end

   assign bus.result    = result_q;
   assign bus.EQ        = eq_q;
   assign bus.valid_out = vld_q;
   assign bus.a0        = rf_q[10];
endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Directed bench for regfile_alu_pipe: reset, forwarding, x0, ALU ops, bubbles, async reset.
module tb_regfile_alu_pipe;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 3;

   logic clk;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   regfile_alu_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CTRL_WIDTH(CW)) bus ();

   regfile_alu_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CTRL_WIDTH(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one op, then step to 1 time unit past the edge that registers it.
   task automatic issue(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [AW-1:0] a3, input logic we,
                        input logic [DW-1:0] imm, input logic src,
                        input logic [CW-1:0] ctrl);
      bus.valid_in = 1'b1; bus.AD1 = a1; bus.AD2 = a2; bus.AD3 = a3;
      bus.WE3 = we; bus.ImmOp = imm; bus.ALUsrc = src; bus.ALUctrl = ctrl;
      @(posedge clk); #1;
   endtask

   task automatic bubble(input logic [AW-1:0] a3, input logic we, input logic [DW-1:0] imm);
      bus.valid_in = 1'b0; bus.AD1 = '0; bus.AD2 = '0; bus.AD3 = a3;
      bus.WE3 = we; bus.ImmOp = imm; bus.ALUsrc = 1'b1; bus.ALUctrl = 3'b000;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bubble(5'd0, 1'b0, '0);
      bubble(5'd0, 1'b0, '0);
      tests++; if (bus.result !== 32'd0) begin fails++; $display("FAIL rst_result got=%0h exp=0", bus.result); end
      tests++; if (bus.EQ !== 1'b0) begin fails++; $display("FAIL rst_eq got=%0b exp=0", bus.EQ); end
      tests++; if (bus.valid_out !== 1'b0) begin fails++; $display("FAIL rst_valid got=%0b exp=0", bus.valid_out); end
      tests++; if (bus.a0 !== 32'd0) begin fails++; $display("FAIL rst_a0 got=%0h exp=0", bus.a0); end
      rst_n = 1'b1;
      issue(5'd0, 5'd0, 5'd10, 1'b1, 32'd5, 1'b1, 3'b000);
      tests++; if (bus.result !== 32'd5) begin fails++; $display("FAIL imm_result got=%0h exp=5", bus.result); end
      tests++; if (bus.valid_out !== 1'b1) begin fails++; $display("FAIL imm_valid got=%0b exp=1", bus.valid_out); end
      tests++; if (bus.a0 !== 32'd0) begin fails++; $display("FAIL imm_a0_early got=%0h exp=0", bus.a0); end
      bubble(5'd0, 1'b0, '0);
      tests++; if (bus.a0 !== 32'd5) begin fails++; $display("FAIL imm_a0 got=%0h exp=5", bus.a0); end
   endtask

   task automatic test_back_to_back;
      issue(5'd0, 5'd0, 5'd1, 1'b1, 32'd7, 1'b1, 3'b000);
      tests++; if (bus.result !== 32'd7) begin fails++; $display("FAIL b2b_x1 got=%0h exp=7", bus.result); end
      issue(5'd1, 5'd1, 5'd2, 1'b1, 32'd0, 1'b0, 3'b000);
      tests++; if (bus.result !== 32'd14) begin fails++; $display("FAIL b2b_x2 got=%0h exp=14", bus.result); end
      tests++; if (bus.valid_out !== 1'b1) begin fails++; $display("FAIL b2b_valid got=%0b exp=1", bus.valid_out); end
      issue(5'd2, 5'd1, 5'd3, 1'b1, 32'd0, 1'b0, 3'b001);
      tests++; if (bus.result !== 32'd7) begin fails++; $display("FAIL b2b_x3 got=%0h exp=7", bus.result); end
      issue(5'd2, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 3'b000);
      tests++; if (bus.result !== 32'd14) begin fails++; $display("FAIL b2b_x2_array got=%0h exp=14", bus.result); end
      issue(5'd3, 5'd1, 5'd0, 1'b0, 32'd0, 1'b0, 3'b000);
      tests++; if (bus.result !== 32'd14) begin fails++; $display("FAIL b2b_x3_plus_x1 got=%0h exp=14", bus.result); end
   endtask

   task automatic test_x0;
      issue(5'd0, 5'd0, 5'd0, 1'b1, 32'd9, 1'b1, 3'b000);
      tests++; if (bus.result !== 32'd9) begin fails++; $display("FAIL x0_write_result got=%0h exp=9", bus.result); end
      issue(5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, 3'b000);
      tests++; if (bus.result !== 32'd0) begin fails++; $display("FAIL x0_fwd_result got=%0h exp=0", bus.result); end
      tests++; if (bus.EQ !== 1'b1) begin fails++; $display("FAIL x0_fwd_eq got=%0b exp=1", bus.EQ); end
      issue(5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, 3'b000);
      tests++; if (bus.result !== 32'd0) begin fails++; $display("FAIL x0_array_result got=%0h exp=0", bus.result); end
   endtask

   task automatic test_alu;
      issue(5'd0, 5'd0, 5'd4, 1'b1, 32'hFFFF_FFF0, 1'b1, 3'b000);
      issue(5'd0, 5'd0, 5'd5, 1'b1, 32'd4, 1'b1, 3'b000);
      issue(5'd4, 5'd5, 5'd0, 1'b0, 32'd0, 1'b0, 3'b111);
      tests++; if (bus.result !== 32'd1) begin fails++; $display("FAIL slt got=%0h exp=1", bus.result); end
      tests++; if (bus.EQ !== 1'b0) begin fails++; $display("FAIL slt_eq got=%0b exp=0", bus.EQ); end
      issue(5'd5, 5'd4, 5'd0, 1'b0, 32'd0, 1'b0, 3'b111);
      tests++; if (bus.result !== 32'd0) begin fails++; $display("FAIL slt_rev got=%0h exp=0", bus.result); end
      issue(5'd4, 5'd5, 5'd0, 1'b0, 32'd0, 1'b0, 3'b110);
      tests++; if (bus.result !== 32'h0FFF_FFFF) begin fails++; $display("FAIL srl got=%0h exp=0fffffff", bus.result); end
      issue(5'd5, 5'd0, 5'd0, 1'b0, 32'h21, 1'b1, 3'b101);
      tests++; if (bus.result !== 32'd8) begin fails++; $display("FAIL sll got=%0h exp=8", bus.result); end
      issue(5'd4, 5'd4, 5'd0, 1'b0, 32'd0, 1'b0, 3'b100);
      tests++; if (bus.result !== 32'd0) begin fails++; $display("FAIL xor got=%0h exp=0", bus.result); end
      tests++; if (bus.EQ !== 1'b1) begin fails++; $display("FAIL xor_eq got=%0b exp=1", bus.EQ); end
      issue(5'd4, 5'd5, 5'd0, 1'b0, 32'd0, 1'b0, 3'b010);
      tests++; if (bus.result !== 32'd0) begin fails++; $display("FAIL and got=%0h exp=0", bus.result); end
      issue(5'd4, 5'd5, 5'd0, 1'b0, 32'd0, 1'b0, 3'b011);
      tests++; if (bus.result !== 32'hFFFF_FFF4) begin fails++; $display("FAIL or got=%0h exp=fffffff4", bus.result); end
      issue(5'd5, 5'd4, 5'd0, 1'b0, 32'd0, 1'b0, 3'b001);
      tests++; if (bus.result !== 32'd20) begin fails++; $display("FAIL sub got=%0h exp=14", bus.result); end
   endtask

   task automatic test_bubble;
      issue(5'd0, 5'd0, 5'd6, 1'b1, 32'd3, 1'b1, 3'b000);
      bubble(5'd6, 1'b1, 32'd99);
      tests++; if (bus.valid_out !== 1'b0) begin fails++; $display("FAIL bubble_valid got=%0b exp=0", bus.valid_out); end
      tests++; if (bus.result !== 32'd3) begin fails++; $display("FAIL bubble_hold got=%0h exp=3", bus.result); end
      bubble(5'd10, 1'b1, 32'd77);
      issue(5'd0, 5'd0, 5'd7, 1'b1, 32'd11, 1'b1, 3'b000);
      tests++; if (bus.result !== 32'd11) begin fails++; $display("FAIL bubble_x7 got=%0h exp=b", bus.result); end
      issue(5'd6, 5'd7, 5'd0, 1'b0, 32'd0, 1'b0, 3'b000);
      tests++; if (bus.result !== 32'd14) begin fails++; $display("FAIL bubble_x6_x7 got=%0h exp=e", bus.result); end
      tests++; if (bus.a0 !== 32'd5) begin fails++; $display("FAIL bubble_a0 got=%0h exp=5", bus.a0); end
   endtask

   task automatic test_async_reset;
      issue(5'd0, 5'd0, 5'd10, 1'b1, 32'h55, 1'b1, 3'b000);
      tests++; if (bus.result !== 32'h55) begin fails++; $display("FAIL ar_issue got=%0h exp=55", bus.result); end
      bus.valid_in = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      tests++; if (bus.a0 !== 32'd0) begin fails++; $display("FAIL ar_a0 got=%0h exp=0", bus.a0); end
      tests++; if (bus.result !== 32'd0) begin fails++; $display("FAIL ar_result got=%0h exp=0", bus.result); end
      tests++; if (bus.valid_out !== 1'b0) begin fails++; $display("FAIL ar_valid got=%0b exp=0", bus.valid_out); end
      @(posedge clk); #1;
      tests++; if (bus.a0 !== 32'd0) begin fails++; $display("FAIL ar_a0_held got=%0h exp=0", bus.a0); end
      rst_n = 1'b1;
      issue(5'd10, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 3'b000);
      tests++; if (bus.result !== 32'd0) begin fails++; $display("FAIL ar_x10 got=%0h exp=0", bus.result); end
      issue(5'd6, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 3'b000);
      tests++; if (bus.result !== 32'd0) begin fails++; $display("FAIL ar_x6 got=%0h exp=0", bus.result); end
      bubble(5'd0, 1'b0, '0);
      tests++; if (bus.a0 !== 32'd0) begin fails++; $display("FAIL ar_a0_after got=%0h exp=0", bus.a0); end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.valid_in = 1'b0; bus.AD1 = '0; bus.AD2 = '0; bus.AD3 = '0;
      bus.WE3 = 1'b0; bus.ImmOp = '0; bus.ALUsrc = 1'b0; bus.ALUctrl = '0;
      #1;
      test_reset;
      test_back_to_back;
      test_x0;
      test_alu;
      test_bubble;
      test_async_reset;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
